// File: rtl/alu_tile_pair.sv
// Dual west/east pipelined ALU channels for the FABulous user project.
// Each channel: stage 1 captures operands, stage 2 computes results, accumulator and op counter.
module alu_tile_pair #(
  parameter int unsigned WIDTH = 36,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] W_OPA,
  input  logic [WIDTH-1:0] W_OPB,
  input  logic [2:0]       W_OP,
  input  logic             W_VALID,
  input  logic [WIDTH-1:0] E_OPA,
  input  logic [WIDTH-1:0] E_OPB,
  input  logic [2:0]       E_OP,
  input  logic             E_VALID,
  output logic [WIDTH-1:0] W_RES0,
  output logic [WIDTH-1:0] W_RES1,
  output logic [WIDTH-1:0] W_RES2,
  output logic             W_VOUT,
  output logic [WIDTH-1:0] E_RES0,
  output logic [WIDTH-1:0] E_RES1,
  output logic [WIDTH-1:0] E_RES2,
  output logic             E_VOUT
);

  localparam int unsigned FW = WIDTH - 4;

  localparam logic [2:0] OP_LOGIC = 3'b000;
  localparam logic [2:0] OP_ARITH = 3'b001;
  localparam logic [2:0] OP_XOR   = 3'b010;
  localparam logic [2:0] OP_ACC   = 3'b011;
  localparam logic [2:0] OP_LOAD  = 3'b100;

  // Index 0 = west, 1 = east
  logic [WIDTH-1:0] opa_in  [2];
  logic [WIDTH-1:0] opb_in  [2];
  logic [2:0]       op_in   [2];
  logic             vld_in  [2];
  logic [WIDTH-1:0] res0_out[2];
  logic [WIDTH-1:0] res1_out[2];
  logic [WIDTH-1:0] res2_out[2];
  logic             vout_out[2];

  assign opa_in[0] = W_OPA;
  assign opb_in[0] = W_OPB;
  assign op_in[0]  = W_OP;
  assign vld_in[0] = W_VALID;
  assign opa_in[1] = E_OPA;
  assign opb_in[1] = E_OPB;
  assign op_in[1]  = E_OP;
  assign vld_in[1] = E_VALID;

  assign W_RES0 = res0_out[0];
  assign W_RES1 = res1_out[0];
  assign W_RES2 = res2_out[0];
  assign W_VOUT = vout_out[0];
  assign E_RES0 = res0_out[1];
  assign E_RES1 = res1_out[1];
  assign E_RES2 = res2_out[1];
  assign E_VOUT = vout_out[1];

  for (genvar g = 0; g < 2; g++) begin : g_ch
    logic             v1_q;
    logic [WIDTH-1:0] a_q, b_q;
    logic [2:0]       op_q;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic             ovf_q, ovf_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] res0_q, res1_q, res2_q;
    logic [WIDTH-1:0] res0_d, res1_d, res2_d;
    logic             vout_q;
    logic [WIDTH:0]   sum_ab, sum_acc;
    logic             carry, zero, err;

    // Stage-2 datapath: results, accumulator and status for the op held in stage 1
    always_comb begin
      sum_ab  = {1'b0, a_q} + {1'b0, b_q};
      sum_acc = {1'b0, acc_q} + {1'b0, a_q};
      res1_d  = '0;
      res2_d  = '0;
      carry   = 1'b0;
      err     = 1'b0;
      acc_d   = acc_q;
      ovf_d   = ovf_q;
      unique case (op_q)
        OP_LOGIC: begin
          res1_d = a_q & b_q;
          res2_d = a_q | b_q;
        end
        OP_ARITH: begin
          res1_d = sum_ab[WIDTH-1:0];
          res2_d = a_q - b_q;
          carry  = sum_ab[WIDTH];
        end
        OP_XOR: begin
          res1_d = a_q ^ b_q;
          res2_d = ~a_q;
        end
        OP_ACC: begin
          acc_d  = sum_acc[WIDTH-1:0];
          res1_d = sum_acc[WIDTH-1:0];
          res2_d = b_q;
          carry  = sum_acc[WIDTH];
          ovf_d  = ovf_q | sum_acc[WIDTH];
        end
        OP_LOAD: begin
          acc_d  = a_q;
          res1_d = a_q;
          ovf_d  = 1'b0;
        end
        default: err = 1'b1;
      endcase
      cnt_d  = cnt_q + CNT_W'(1);
      zero   = (res1_d == '0);
      res0_d = {FW'(cnt_d), carry, zero, ovf_d, err};
    end

    // Both stages advance only when en=1; en=0 freezes the whole channel
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v1_q   <= 1'b0;
        a_q    <= '0;
        b_q    <= '0;
        op_q   <= '0;
        acc_q  <= '0;
        ovf_q  <= 1'b0;
        cnt_q  <= '0;
        res0_q <= '0;
        res1_q <= '0;
        res2_q <= '0;
        vout_q <= 1'b0;
      end else if (en) begin
        v1_q   <= vld_in[g];
        vout_q <= v1_q;
        if (vld_in[g]) begin
          a_q  <= opa_in[g];
          b_q  <= opb_in[g];
          op_q <= op_in[g];
        end
        if (v1_q) begin
          acc_q  <= acc_d;
          ovf_q  <= ovf_d;
          cnt_q  <= cnt_d;
          res0_q <= res0_d;
          res1_q <= res1_d;
          res2_q <= res2_d;
        end
      end
    end

    assign res0_out[g] = res0_q;
    assign res1_out[g] = res1_q;
    assign res2_out[g] = res2_q;
    assign vout_out[g] = vout_q;
  end

endmodule

// File: tb/tb_alu_tile_pair.sv
// Directed + random bench for alu_tile_pair with a per-channel reference model and result queues.
module tb_alu_tile_pair;

  logic        clk, rst_n, en;
  logic [35:0] w_opa, w_opb, e_opa, e_opb;
  logic [2:0]  w_op, e_op;
  logic        w_valid, e_valid;
  logic [35:0] w_r0, w_r1, w_r2, e_r0, e_r1, e_r2;
  logic        w_vout, e_vout;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [35:0] r0;
    logic [35:0] r1;
    logic [35:0] r2;
  } res_t;

  res_t        q_w[$];
  res_t        q_e[$];
  logic [35:0] m_acc [2];
  logic        m_ovf [2];
  logic [3:0]  m_cnt [2];
  logic        m_v1  [2];
  logic        m_vout[2];
  res_t        m_r   [2];

  alu_tile_pair #(.WIDTH(36), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .en(en),
    .W_OPA(w_opa), .W_OPB(w_opb), .W_OP(w_op), .W_VALID(w_valid),
    .E_OPA(e_opa), .E_OPB(e_opb), .E_OP(e_op), .E_VALID(e_valid),
    .W_RES0(w_r0), .W_RES1(w_r1), .W_RES2(w_r2), .W_VOUT(w_vout),
    .E_RES0(e_r0), .E_RES1(e_r1), .E_RES2(e_r2), .E_VOUT(e_vout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [35:0] obs, input logic [35:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic clear_model();
    q_w.delete();
    q_e.delete();
    for (int c = 0; c < 2; c++) begin
      m_acc[c] = '0; m_ovf[c] = 1'b0; m_cnt[c] = '0;
      m_v1[c] = 1'b0; m_vout[c] = 1'b0; m_r[c] = '0;
    end
  endtask

  // Reference model of one stage-2 completion; advances the channel's acc/ovf/cnt
  task automatic model_op(input int ch, input logic [2:0] op, input logic [35:0] a,
                          input logic [35:0] b, output res_t r);
    logic [36:0] s;
    logic        c, er;
    logic [35:0] r1, r2;
    c = 1'b0; er = 1'b0; r1 = '0; r2 = '0;
    case (op)
      3'd0: begin r1 = a & b; r2 = a | b; end
      3'd1: begin s = {1'b0, a} + {1'b0, b}; r1 = s[35:0]; c = s[36]; r2 = a - b; end
      3'd2: begin r1 = a ^ b; r2 = ~a; end
      3'd3: begin
        s = {1'b0, m_acc[ch]} + {1'b0, a};
        m_acc[ch] = s[35:0]; r1 = s[35:0]; r2 = b; c = s[36];
        if (c) m_ovf[ch] = 1'b1;
      end
      3'd4: begin m_acc[ch] = a; r1 = a; r2 = '0; m_ovf[ch] = 1'b0; end
      default: er = 1'b1;
    endcase
    m_cnt[ch] = m_cnt[ch] + 4'd1;
    r.r0 = {32'(m_cnt[ch]), c, (r1 == 36'd0), m_ovf[ch], er};
    r.r1 = r1;
    r.r2 = r2;
  endtask

  task automatic check_ch(input int ch);
    if (ch == 0) begin
      chk("W_VOUT", 36'(w_vout), 36'(m_vout[0]));
      chk("W_RES0", w_r0, m_r[0].r0);
      chk("W_RES1", w_r1, m_r[0].r1);
      chk("W_RES2", w_r2, m_r[0].r2);
    end else begin
      chk("E_VOUT", 36'(e_vout), 36'(m_vout[1]));
      chk("E_RES0", e_r0, m_r[1].r0);
      chk("E_RES1", e_r1, m_r[1].r1);
      chk("E_RES2", e_r2, m_r[1].r2);
    end
  endtask

  // Update the model for the coming edge, clock once, then compare both channels
  task automatic tick();
    res_t r;
    if (en && rst_n) begin
      m_vout[0] = m_v1[0];
      if (m_v1[0] && q_w.size() > 0) m_r[0] = q_w.pop_front();
      m_vout[1] = m_v1[1];
      if (m_v1[1] && q_e.size() > 0) m_r[1] = q_e.pop_front();
      m_v1[0] = w_valid;
      if (w_valid) begin model_op(0, w_op, w_opa, w_opb, r); q_w.push_back(r); end
      m_v1[1] = e_valid;
      if (e_valid) begin model_op(1, e_op, e_opa, e_opb, r); q_e.push_back(r); end
    end
    @(posedge clk);
    #1;
    check_ch(0);
    check_ch(1);
  endtask

  task automatic step(input logic en_v,
                      input logic wv, input logic [2:0] wo, input logic [35:0] wa, input logic [35:0] wb,
                      input logic ev, input logic [2:0] eo, input logic [35:0] ea, input logic [35:0] eb);
    en = en_v;
    w_valid = wv; w_op = wo; w_opa = wa; w_opb = wb;
    e_valid = ev; e_op = eo; e_opa = ea; e_opb = eb;
    tick();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 3'd0, '0, '0, 1'b0, 3'd0, '0, '0);
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0;
    w_valid = 1'b0; w_op = '0; w_opa = '0; w_opb = '0;
    e_valid = 1'b0; e_op = '0; e_opa = '0; e_opb = '0;
    clear_model();
    #3;
    check_ch(0);
    check_ch(1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // West ARITH wrap: 0xFFFFFFFFF + 1, accepted in the first cycle after reset release
    step(1'b1, 1'b1, 3'd1, 36'hF_FFFF_FFFF, 36'd1, 1'b0, 3'd0, '0, '0);
    idle(1);
    chk("W_ARITH_RES0", w_r0, {32'd1, 4'b1100});
    chk("W_ARITH_RES2", w_r2, 36'hF_FFFF_FFFE);
    idle(2);

    // East accumulator chain, with west LOGIC/XOR traffic alongside
    step(1'b1, 1'b1, 3'd0, 36'hF0F0_F0F0F, 36'h0FF0_0FF00, 1'b1, 3'd4, 36'd5, '0);
    step(1'b1, 1'b1, 3'd2, 36'h1234_56789, 36'hFFFF_00000, 1'b1, 3'd3, 36'd3, 36'd11);
    step(1'b1, 1'b0, 3'd0, '0, '0, 1'b1, 3'd3, 36'd7, 36'd22);
    idle(1);
    chk("E_ACC_CHAIN", e_r1, 36'd15);
    step(1'b1, 1'b0, 3'd0, '0, '0, 1'b1, 3'd4, 36'hF_FFFF_FFFF, '0);
    step(1'b1, 1'b0, 3'd0, '0, '0, 1'b1, 3'd3, 36'd2, '0);
    step(1'b1, 1'b0, 3'd0, '0, '0, 1'b1, 3'd3, 36'd1, '0);
    step(1'b1, 1'b0, 3'd0, '0, '0, 1'b1, 3'd4, 36'd4, '0);
    idle(2);

    // Stall with VOUT low, then with VOUT high across the freeze
    step(1'b1, 1'b1, 3'd2, 36'hA_AAAA_AAAA, 36'h5_5555_5555, 1'b0, 3'd0, '0, '0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 3'd1, 36'd9, 36'd9, 1'b1, 3'd4, 36'd9, '0);
    idle(2);
    step(1'b1, 1'b1, 3'd1, 36'd100, 36'd200, 1'b1, 3'd3, 36'd10, '0);
    step(1'b1, 1'b1, 3'd0, 36'd7, 36'd3, 1'b0, 3'd0, '0, '0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 3'd0, '0, '0, 1'b0, 3'd0, '0, '0);
    idle(2);

    // Reserved opcode then a normal op on east
    step(1'b1, 1'b0, 3'd0, '0, '0, 1'b1, 3'd6, 36'd123, 36'd456);
    step(1'b1, 1'b0, 3'd0, '0, '0, 1'b1, 3'd0, 36'hFF, 36'h0F);
    idle(2);

    // West: 16 back-to-back ops to wrap the 4-bit counter
    for (int i = 0; i < 16; i++) step(1'b1, 1'b1, 3'(i % 5), 36'(i * 3 + 1), 36'(i), 1'b0, 3'd0, '0, '0);
    idle(2);

    // Simultaneous random traffic with occasional stalls
    for (int i = 0; i < 60; i++) begin
      step(($urandom_range(0, 9) != 0),
           1'($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)),
           {4'($urandom), 32'($urandom)}, {4'($urandom), 32'($urandom)},
           1'($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)),
           {4'($urandom), 32'($urandom)}, {4'($urandom), 32'($urandom)});
    end
    idle(2);

    // Asynchronous reset with ops in flight on both channels
    step(1'b1, 1'b1, 3'd1, 36'd5, 36'd6, 1'b1, 3'd4, 36'd77, '0);
    #2;
    rst_n = 1'b0;
    #1;
    clear_model();
    check_ch(0);
    check_ch(1);
    tick();
    rst_n = 1'b1;
    idle(3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_tile_pair.md
# alu_tile_pair

Parametrised dual-side operand/result block for the FABulous user project. It replaces the fixed-constant W/E result drivers with two independent pipelined ALU channels, one west and one east. Each channel takes two operands plus an opcode with a valid strobe and returns three result words two cycles later. It also keeps a per-channel accumulator and an accepted-operation counter, carrying forward the enable/reset-counter behaviour of the earlier user design.

## Interface
- WIDTH, 36: operand/result width, ≥8
- CNT_W, 16: accepted-op counter width, ≤ WIDTH-4
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- en  in  1  global pipeline advance; 0 = both channels frozen
- W_OPA, W_OPB  in  WIDTH  west operands
- W_OP  in  3  west opcode
- W_VALID  in  1  west operation strobe
- E_OPA, E_OPB, E_OP, E_VALID  in  WIDTH/WIDTH/3/1  east equivalents
- W_RES0, W_RES1, W_RES2  out  WIDTH  west status / primary / secondary result
- W_VOUT  out  1  west result valid, one-cycle pulse
- E_RES0, E_RES1, E_RES2, E_VOUT  out  east equivalents

## Operation
- The two channels are identical and fully independent; only clk, rst_n and en are shared. The rest of this section describes one channel (X = W or E).
- Stage 1, when en=1: X_VALID=1 captures OPA, OPB and OP and sets v1. X_VALID=0 clears v1. An operation is "accepted" when en=1 and X_VALID=1.
- Stage 2, when en=1 and v1=1: computes and registers RES1 and RES2, updates acc, increments cnt, and pulses VOUT.
- Stage 2, when en=1 and v1=0: VOUT=0. RES0..2 hold their values.
- Opcodes (A, B = stage-1 operands, arithmetic mod 2^WIDTH, carry = bit WIDTH of the unsigned sum):
  - 000 LOGIC: RES1=A&B, RES2=A|B
  - 001 ARITH: RES1=A+B, RES2=A−B; carry=carry-out of A+B
  - 010 XOR: RES1=A^B, RES2=~A
  - 011 ACC: acc←acc+A; RES1=new acc; RES2=B; carry=carry-out of acc+A; accovf is sticky
  - 100 LOAD: acc←A; RES1=A; RES2=0; clears accovf
  - 101–111 reserved: RES1=RES2=0, acc unchanged, err flag set
- Carry is 0 for every opcode except ARITH and ACC.
- cnt is CNT_W bits, increments on every stage-2 completion (including reserved opcodes), and wraps from all-ones to 0.
- RES0 = {zero-extended cnt (after increment), carry, z, accovf, err}, occupying bits [WIDTH-1:4] and [3:0]. z=1 when the new RES1 is 0. err applies to this op only; it is not sticky.
- en=0 freezes everything: v1, operands, acc, cnt, and all outputs. VOUT keeps its current value and does not re-pulse. X_VALID presented while en=0 is ignored.

## Timing
- Latency is 2 cycles: accepted at edge N → RES*/VOUT updated at edge N+1 (stall cycles add 1 each).
- Throughput is 1 op/cycle/channel. Back-to-back ACC ops chain correctly: each op sees the acc written by the previous op.
- Reset (rst_n=0, asynchronous): v1=0, acc=0, accovf=0, cnt=0, all RES*=0, VOUT=0. Reset is honoured mid-pipeline; in-flight ops are discarded and no VOUT follows release.
- Operations fed into the pipeline in the first cycle after rst_n deasserts are accepted normally.
- W and E may complete on the same cycle with no interaction between them.

## Test plan
- Reset: assert rst_n=0 mid-op, release → all RES=0, VOUT=0, no spurious pulse afterwards.
- W ARITH with A=0xFFFFFFFFF, B=1 (WIDTH=36) → two cycles later W_RES1=0, W_RES2=0xFFFFFFFFE, carry=1, z=1, count field=1, W_VOUT pulses once.
- E LOAD 5, then ACC 3, ACC 7 on consecutive cycles → E_RES1 = 5, 8, 15 on consecutive cycles. Next, LOAD 0xFFFFFFFFF, then ACC 2 → RES1=1, carry=1, accovf=1. A following ACC 1 keeps accovf=1 until the next LOAD.
- Stall: accept an op, drop en for 3 cycles → results and VOUT frozen with no duplicate pulse. Result arrives on the 2nd enabled edge.
- Reserved opcode 110 → RES1=RES2=0, err=1, acc unchanged, count still increments. Next valid op → err=0.
- Counter wrap with CNT_W=4: 16 valid ops → count field returns to 0. Simultaneous W/E random traffic matches the reference model per channel.
